// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcode field values, loader state encoding,
// loader error codes and the default frame start marker.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_COUNT    = 2'd1,
    ERR_CHECKSUM = 2'd2,
    ERR_OPCODE   = 2'd3
  } loader_err_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
      OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_SLTI,
      OP_BNEQZ, OP_BEQZ, OP_HLT: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte stream in, memory write bus and status out for the program loader.
interface mips32_prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_start, busy, done, err
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_start, busy, done, err
  );
endinterface

// File: rtl/mips32_prog_loader_word_asm.sv
// Big-endian byte-to-word assembler with running XOR of every data byte.
module mips32_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_last,
  output logic [7:0]  xor_out
);
  logic [7:0] lane_reg [0:2];
  logic [1:0] idx_reg;
  logic [7:0] xor_reg;

  // lane 0 holds the newest byte; older bytes move up toward the MSB
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_in;
      if (gi == 0) begin : g_first
        assign lane_in = byte_in;
      end else begin : g_rest
        assign lane_in = lane_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          lane_reg[gi] <= 8'h00;
        end else if (byte_en) begin
          lane_reg[gi] <= lane_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_reg <= 2'd0;
      xor_reg <= 8'h00;
    end else if (byte_en) begin
      idx_reg <= idx_reg + 2'd1;
      xor_reg <= xor_reg ^ byte_in;
    end
  end

  assign word_out  = {lane_reg[2], lane_reg[1], lane_reg[0], byte_in};
  assign word_last = byte_en && (idx_reg == 2'd3);
  assign xor_out   = xor_reg;
endmodule

// File: rtl/mips32_prog_loader.sv
// Loads framed program words from a byte stream into MIPS32 memory, checks
// count, checksum and opcodes, then releases the core.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int         MEM_DEPTH = 1024,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input logic                  clk,
  input logic                  rst,
  mips32_prog_loader_if.master bus
);
  localparam logic [16:0] MAX_COUNT = 17'(MEM_DEPTH);

  loader_state_t state_reg, state_next;
  loader_err_t   err_reg, err_next;
  logic [15:0]   count_reg, count_next;
  logic [15:0]   word_cnt_reg, word_cnt_next;
  logic [9:0]    addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic          we_reg, we_next;
  logic          start_reg, start_next;
  logic          done_reg, done_next;
  logic          illegal_reg, illegal_next;

  logic          accept;
  logic          asm_clear;
  logic          asm_en;
  logic          asm_last;
  logic [31:0]   asm_word;
  logic [7:0]    asm_xor;
  logic [15:0]   count_full;

  assign bus.rx_ready = 1'b1;
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign asm_en       = accept && (state_reg == DATA);
  assign count_full   = {count_reg[15:8], bus.rx_data};

  mips32_word_asm u_word_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_in   (bus.rx_data),
    .word_out  (asm_word),
    .word_last (asm_last),
    .xor_out   (asm_xor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      err_reg      <= ERR_NONE;
      count_reg    <= 16'd0;
      word_cnt_reg <= 16'd0;
      addr_reg     <= 10'd0;
      wdata_reg    <= 32'd0;
      we_reg       <= 1'b0;
      start_reg    <= 1'b0;
      done_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      err_reg      <= err_next;
      count_reg    <= count_next;
      word_cnt_reg <= word_cnt_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      we_reg       <= we_next;
      start_reg    <= start_next;
      done_reg     <= done_next;
      illegal_reg  <= illegal_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    err_next      = err_reg;
    count_next    = count_reg;
    word_cnt_next = word_cnt_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    we_next       = 1'b0;
    start_next    = 1'b0;
    done_next     = done_reg;
    illegal_next  = illegal_reg;
    asm_clear     = 1'b0;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_next    = CNT_HI;
          err_next      = ERR_NONE;
          done_next     = 1'b0;
          word_cnt_next = 16'd0;
          addr_next     = 10'd0;
          illegal_next  = 1'b0;
          asm_clear     = 1'b1;
        end
      end
      CNT_HI: begin
        if (accept) begin
          count_next = {bus.rx_data, 8'h00};
          state_next = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          count_next = count_full;
          if ((count_full == 16'd0) || ({1'b0, count_full} > MAX_COUNT)) begin
            state_next = ERR;
            err_next   = ERR_COUNT;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        // the word is written even when its opcode is illegal
        if (asm_last) begin
          we_next       = 1'b1;
          wdata_next    = asm_word;
          addr_next     = word_cnt_reg[9:0];
          word_cnt_next = word_cnt_reg + 16'd1;
          if (!opcode_legal(asm_word[31:26])) begin
            illegal_next = 1'b1;
          end
          if (word_cnt_reg == count_reg - 16'd1) begin
            state_next = CHK;
          end
        end
      end
      CHK: begin
        if (accept) begin
          if (bus.rx_data != asm_xor) begin
            state_next = ERR;
            err_next   = ERR_CHECKSUM;
          end else if (illegal_reg) begin
            state_next = ERR;
            err_next   = ERR_OPCODE;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
            start_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_we    = we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.cpu_start = start_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.busy      = (state_reg == CNT_HI) || (state_reg == CNT_LO) ||
                         (state_reg == DATA)   || (state_reg == CHK);
endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for the program loader: frames in, memory writes and status checked.
module tb_mips32_prog_loader;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  int          wr_cnt;
  int          start_cnt;
  logic [31:0] tb_mem [0:1023];

  mips32_prog_loader_if bus ();

  mips32_prog_loader #(.MEM_DEPTH(1024), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model and pulse counters, sampled at the active edge
  always @(posedge clk) begin
    if (bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.cpu_start) start_cnt <= start_cnt + 1;
  end

  initial begin
    wr_cnt    = 0;
    start_cnt = 0;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_reset(input logic valid_during, input logic [7:0] data_during);
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = valid_during;
    bus.rx_data  = data_during;
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset(1'b0, 8'h00);
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.mem_addr !== 10'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    total++; if ({bus.cpu_start, bus.busy, bus.done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus.cpu_start, bus.busy, bus.done}); end
    total++; if (bus.err !== 2'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", bus.err); end
    $display("reset applied");
  endtask

  task automatic test_basic();
    int w0, s0;
    w0 = wr_cnt; s0 = start_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    send_word(32'h2801000a); send_word(32'h28020014); send_word(32'h28030019);
    send_byte(8'h2F);
    idle(3);
    total++; if (wr_cnt - w0 !== 3) begin bad++; $display("FAIL basic_writes got=%0d exp=3", wr_cnt - w0); end
    total++; if (tb_mem[0] !== 32'h2801000a) begin bad++; $display("FAIL basic_mem0 got=%h exp=2801000a", tb_mem[0]); end
    total++; if (tb_mem[1] !== 32'h28020014) begin bad++; $display("FAIL basic_mem1 got=%h exp=28020014", tb_mem[1]); end
    total++; if (tb_mem[2] !== 32'h28030019) begin bad++; $display("FAIL basic_mem2 got=%h exp=28030019", tb_mem[2]); end
    total++; if (bus.mem_addr !== 10'd2) begin bad++; $display("FAIL basic_last_addr got=%0d exp=2", bus.mem_addr); end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL basic_start got=%0d exp=1", start_cnt - s0); end
    total++; if ({bus.done, bus.busy, bus.err} !== 4'b1000) begin bad++; $display("FAIL basic_status got=%b exp=1000", {bus.done, bus.busy, bus.err}); end
    $display("frame 3 words sent, checksum 2F");
  endtask

  task automatic test_bad_count();
    int w0;
    w0 = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    total++; if (bus.err !== 2'd1) begin bad++; $display("FAIL count0_err got=%0d exp=1", bus.err); end
    total++; if ({bus.done, bus.busy} !== 2'b00) begin bad++; $display("FAIL count0_flags got=%b exp=00", {bus.done, bus.busy}); end
    $display("frame count 0 sent");
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h00);
    idle(2);
    total++; if (bus.err !== 2'd1) begin bad++; $display("FAIL count1025_err got=%0d exp=1", bus.err); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL badcount_writes got=%0d exp=0", wr_cnt - w0); end
    $display("frame count 1025 sent");
  endtask

  task automatic test_checksum();
    int w0, s0;
    w0 = wr_cnt; s0 = start_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h0ce77800);
    send_byte(8'h6C);
    idle(3);
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL chk_writes got=%0d exp=1", wr_cnt - w0); end
    total++; if (tb_mem[0] !== 32'h0ce77800) begin bad++; $display("FAIL chk_mem0 got=%h exp=0ce77800", tb_mem[0]); end
    total++; if (bus.err !== 2'd2) begin bad++; $display("FAIL chk_err got=%0d exp=2", bus.err); end
    total++; if (start_cnt - s0 !== 0) begin bad++; $display("FAIL chk_start got=%0d exp=0", start_cnt - s0); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL chk_done got=%b exp=0", bus.done); end
    $display("frame with flipped checksum sent");
  endtask

  task automatic test_opcode();
    int w0, s0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(32'hFC000000); send_byte(8'hFC);
    idle(3);
    total++; if ({bus.done, bus.err} !== 3'b100) begin bad++; $display("FAIL hlt_status got=%b exp=100", {bus.done, bus.err}); end
    $display("frame HLT word sent");
    w0 = wr_cnt; s0 = start_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h40000000); send_byte(8'h40);
    idle(3);
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL illop_writes got=%0d exp=1", wr_cnt - w0); end
    total++; if (tb_mem[0] !== 32'h40000000) begin bad++; $display("FAIL illop_mem0 got=%h exp=40000000", tb_mem[0]); end
    total++; if (bus.err !== 2'd3) begin bad++; $display("FAIL illop_err got=%0d exp=3", bus.err); end
    total++; if ((start_cnt - s0 !== 0) || (bus.done !== 1'b0)) begin bad++; $display("FAIL illop_start got=%0d done=%b exp=0/0", start_cnt - s0, bus.done); end
    $display("frame illegal opcode sent");
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h40000000); send_byte(8'h41);
    idle(3);
    total++; if (bus.err !== 2'd2) begin bad++; $display("FAIL illop_chk_prio got=%0d exp=2", bus.err); end
    $display("frame illegal opcode with bad checksum sent");
  endtask

  task automatic test_rst_mid();
    int w0;
    w0 = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h28); send_byte(8'h01);
    pulse_reset(1'b1, 8'hA5);
    idle(2);
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL rstmid_writes got=%0d exp=0", wr_cnt - w0); end
    total++; if ({bus.busy, bus.done, bus.err} !== 4'b0000) begin bad++; $display("FAIL rstmid_state got=%b exp=0000", {bus.busy, bus.done, bus.err}); end
    $display("reset mid-frame applied");
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(32'h2801000a); send_word(32'h28020014);
    send_byte(8'h1D);
    idle(3);
    total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL rstmid_reload_writes got=%0d exp=2", wr_cnt - w0); end
    total++; if ((tb_mem[0] !== 32'h2801000a) || (tb_mem[1] !== 32'h28020014)) begin bad++; $display("FAIL rstmid_reload_mem got=%h %h exp=2801000a 28020014", tb_mem[0], tb_mem[1]); end
    total++; if ({bus.done, bus.err} !== 3'b100) begin bad++; $display("FAIL rstmid_reload_status got=%b exp=100", {bus.done, bus.err}); end
    $display("frame 2 words sent after reset");
  endtask

  task automatic test_back_to_back();
    int w0, s0;
    w0 = wr_cnt; s0 = start_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h2801000a); send_byte(8'h23);
    send_byte(8'hA5); send_byte(8'h00);
    total++; if ({bus.done, bus.busy} !== 2'b01) begin bad++; $display("FAIL b2b_done_cleared got=%b exp=01", {bus.done, bus.busy}); end
    send_byte(8'h01);
    send_word(32'h28A5A5A5); send_byte(8'h8D);
    idle(3);
    total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL b2b_writes got=%0d exp=2", wr_cnt - w0); end
    total++; if (tb_mem[0] !== 32'h28A5A5A5) begin bad++; $display("FAIL b2b_mem0 got=%h exp=28a5a5a5", tb_mem[0]); end
    total++; if (start_cnt - s0 !== 2) begin bad++; $display("FAIL b2b_start got=%0d exp=2", start_cnt - s0); end
    total++; if ({bus.done, bus.err} !== 3'b100) begin bad++; $display("FAIL b2b_status got=%b exp=100", {bus.done, bus.err}); end
    $display("garbage then two back-to-back frames sent");
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_bad_count();
    test_checksum();
    test_opcode();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips32_prog_loader.md
MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024: words in the target instruction/data memory.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port rx_data, input, 8: incoming byte.
REQ-006 SHALL have port rx_valid, input, 1: rx_data is valid.
REQ-007 SHALL have port rx_ready, output, 1: loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we, output, 1: one-cycle write strobe to the MIPS32 Mem array.
REQ-009 SHALL have port mem_addr, output, 10: word address, starting at 0.
REQ-010 SHALL have port mem_wdata, output, 32: assembled instruction word.
REQ-011 SHALL have port cpu_start, output, 1: one-cycle pulse releasing the core (PC=0, HALTED=0).
REQ-012 SHALL have port busy, output, 1: a frame is in progress.
REQ-013 SHALL have port done, output, 1: last frame loaded correctly (sticky).
REQ-014 SHALL have port err, output, 2: 0 none, 1 bad count, 2 checksum, 3 illegal opcode.

Function
REQ-015 SHALL transfer a byte only when rx_valid and rx_ready are both 1 in the same cycle.
REQ-016 SHALL use frame format: SYNC_BYTE, count_hi, count_lo, then count words of 4 bytes each (big-endian, MSB first), then 1 checksum byte.
REQ-017 SHALL have states IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR.
REQ-018 SHALL hold rx_ready at 1 in every state.
REQ-019 SHALL, in IDLE, DONE and ERR, discard bytes other than SYNC_BYTE; an accepted SYNC_BYTE moves to CNT_HI and clears done and err.
REQ-020 SHALL, on the byte after count_lo, go to ERR with err=1 when count is 0 or exceeds MEM_DEPTH, with no memory write.
REQ-021 SHALL assert mem_we for exactly 1 cycle, the cycle after the 4th byte of a word is accepted; mem_addr increments after each write; addresses never exceed count-1.
REQ-022 SHALL, with count words written, go to CHK; the checksum is the XOR of all data bytes (header excluded).
REQ-023 SHALL, on checksum match with no illegal opcode seen, go to DONE, pulse cpu_start for 1 cycle on DONE entry, and set done=1.
REQ-024 SHALL, on checksum mismatch, go to ERR with err=2 and not pulse cpu_start.
REQ-025 SHALL treat as illegal any word whose bits [31:26] are not in {ADD, SUB, AND, OR, SLT, MUL, LW, SW, ADDI, SUBI, SLTI, BNEQZ, BEQZ, HLT}; the word is still written, and after a checksum match the state is ERR with err=3.
REQ-026 SHALL give a checksum mismatch priority over an illegal opcode (err=2).
REQ-027 SHALL hold busy=1 in states CNT_HI, CNT_LO, DATA and CHK.
REQ-028 SHALL accept a SYNC_BYTE while busy as ordinary data, never as a restart.
REQ-029 SHALL be fully pipelined with no stalls: back-to-back valid bytes every cycle are accepted.

Reset
REQ-030 SHALL, on rst=1, go to IDLE, set mem_we=0, mem_addr=0, mem_wdata=0, cpu_start=0, busy=0, done=0, err=0, rx_ready=1, and clear the checksum and byte counters.
REQ-031 SHALL give rst priority over a simultaneous rx_valid; that byte is dropped.
REQ-032 SHALL, on rst mid-frame, discard any partial word with no further writes; words already written stay in memory.

Structure
REQ-033 SHALL import opcode constants, state encoding, err codes and the default SYNC_BYTE from shared package mips32_pkg, also used by mips32.
REQ-034 SHALL use one natural sub-module, mips32_word_asm, for byte-to-word shift, byte index and XOR accumulation; the FSM and opcode check stay in the top.

Verification
REQ-035 SHALL cover: A5 00 03 + 2801000a 28020014 28030019 + correct XOR -> 3 writes at addr 0..2 with those data, cpu_start pulse, done=1, err=0.
REQ-036 SHALL cover: A5 00 00 -> ERR, err=1, no mem_we; A5 04 01 (count 1025) -> err=1.
REQ-037 SHALL cover: valid 1-word frame 0ce77800 with checksum byte flipped -> 1 write, err=2, no cpu_start.
REQ-038 SHALL cover: word FC000000 (opcode 111111=HLT) legal; word 40000000 (opcode 010000) -> written, err=3 after a correct checksum.
REQ-039 SHALL cover: rst asserted after the 2nd byte of word 1 of a 2-word frame -> no write for that word, state IDLE; a fresh frame then loads correctly from addr 0.
REQ-040 SHALL cover: leading garbage 00 FF then a valid frame -> garbage ignored; after DONE a second frame clears done and reloads.
